opr_issue_ctrl: RTL and testbench
=================================

// Module: opr_issue_ctrl
// PURPOSE
//  Registered, parametrised successor to the combinational operand decoder. It accepts one instruction at a time over a
//  valid/ready handshake, decodes it into held control selects, and times its execution with an internal delay counter.
//  Long ALU operations wait for alu_done instead of a fixed delay. Exactly one retire pulse ends each instruction.
//  It sits between instruction fetch and the ALU/PRNG/SPRF datapath, and supports NUM_IDX index registers instead of two.
// PARAMETERS
//  OPR_W       5   opcode width
//  DST_W       8   dst_code width
//  DLY_W       8   delay counter width; all-ones value = "wait for alu_done"
//  ALU_TYP_W   4   ALU operation select width
//  PRNG_TYP_W  2   PRNG operation select width
//  SPRF_TYP_W  2   per-index-register select width
//  NUM_IDX     2   number of index registers, addressed at dst_code[5:0] = IDX_BASE+k
//  IDX_BASE    32  dst_code[5:0] address of index register 0
// PORTS
//  clk              in   1                    clock, rising edge
//  rst_b            in   1                    asynchronous reset, active low
//  instr_valid      in   1                    instruction fields valid
//  instr_ready      out  1                    block can accept an instruction
//  opr_code         in   OPR_W                opcode
//  dst_code         in   DST_W                destination code
//  src_typ, dst_typ in   3 each               operand types
//  alu_done         in   1                    ALU completion, sampled in WAIT
//  flush            in   1                    synchronous abort of the current instruction
//  exec_start       out  1                    one-cycle pulse on entry to EXEC/WAIT
//  busy             out  1                    high in any state except IDLE
//  retire           out  1                    one-cycle pulse at instruction end
//  illegal          out  1                    qualifies retire: instruction was not executed
//  opr_typ_sel      out  OPR_W                latched opcode, held until the next accept
//  opr_div_mod_sel  out  1                    DIV/EVAL with src_typ==3'b100
//  alu_o_sel, alu_t_sel out 1 each            ALU operand fetch enables
//  alu_typ_sel      out  ALU_TYP_W            ALU operation
//  prng_t_sel       out  1                    PRNG seed load
//  prng_typ_sel     out  PRNG_TYP_W           PRNG operation
//  sprf_typ_sel     out  NUM_IDX*SPRF_TYP_W   field k controls index register k
//  dly_cnt          out  DLY_W                remaining EXEC cycles (debug)
// BEHAVIOUR
//  Reset: all outputs 0 except instr_ready=1; state IDLE; dly_cnt 0.
//  States: IDLE -> DECODE -> EXEC|WAIT|RETIRE -> RETIRE -> IDLE.
//  IDLE: instr_ready=1. On instr_valid, latch the fields and go to DECODE.
//  DECODE (1 cycle): register all selects; load dly_cnt = D from the table. Legal instructions go to EXEC, or to WAIT
//   when D is all-ones. Illegal instructions go to RETIRE with illegal=1 and all selects 0.
//  EXEC: dly_cnt decrements each cycle; go to RETIRE in the cycle dly_cnt==1. EXEC lasts exactly D cycles.
//  WAIT: go to RETIRE in the cycle alu_done=1. alu_done outside WAIT is ignored.
//  RETIRE (1 cycle): retire=1, then IDLE. Fixed latency = accept edge + 1 + D + 1; the next accept is possible the cycle after RETIRE.
//  Selects hold from DECODE until the next DECODE; the 0-default fields of non-matching ops are cleared in DECODE.
//  flush in DECODE/EXEC/WAIT: go to IDLE next edge; no retire; selects cleared. flush in IDLE/RETIRE is ignored.
//  Latency table D / alu_typ (others 0):
//   MOV(1): @IDX->Rx or Rmod (101,000|100) 4; imm->Rx (010,000) 1; Rx->Rx (000,000) 1; Rx->Rmod (000,100) 1;
//     Rx->@IDX (000,101) 2. Any other type pair is illegal.
//   ADD(2) 4/1; SUB(3) 4/2; MUL(4) wait/3; DIV(5) wait/5; INV(8) 21/6; SPLIT(9) wait/2; DEG(10) wait/7;
//     RSHIFT(11) wait/8; EVAL(12) 34/9; JRE(17) 7/4. All of these set alu_o_sel=alu_t_sel=1.
//   JMP(16) 3, no ALU.
//   PRNG(6): (010,000) D=3, prng_t_sel=1, prng_typ=2; (000,000) D=4, prng_typ=1; any other pair is illegal.
//   IDX(7): dst_typ 000 -> inc (2); dst_typ 001 -> dec (3); D=2; any other dst_typ is illegal.
//   MOV Rx->Rx with dst IDX_BASE+k: field k = 1 (load). IDX ops: field k = 2 or 3.
//   A dst index outside IDX_BASE..IDX_BASE+NUM_IDX-1 leaves all fields 0 (the instruction is still legal).
//   Opcodes 0, 13-15 and >=18 are illegal.
//  Reset asserted mid-operation: immediate return to the reset values; no retire is emitted.
// TESTING
//  ADD accepted at cycle 0: exec_start@2; dly_cnt 4,3,2,1; retire@6; alu_typ_sel=1; instr_ready=1@7.
//  MUL, alu_done at 10 cycles after exec_start: busy holds throughout; retire the cycle after alu_done; alu_typ_sel=3.
//  NUM_IDX=4: IDX dst_typ 001, dst 34: sprf field2=3, other fields 0; D=2. Then dst 40: all fields 0, retire normal.
//  opr_code 13, and PRNG (101,000): no exec_start; retire@2 with illegal=1; all selects 0.
//  flush during the WAIT of DIV: IDLE next edge, no retire. rst_b low during EXEC of EVAL: all outputs return to reset values at once.
//  DIV with src_typ 100: opr_div_mod_sel=1. JMP: D=3, alu_o_sel=0. Back-to-back valid stream: one accept per 3+D cycles.

Source files
------------

// File: rtl/opr_issue_ctrl.sv
// ---------------------------------------------------------------------------
// opr_issue_ctrl
//
// Registered instruction issue controller. It accepts one instruction at a
// time over a valid/ready handshake and latches its fields. One DECODE cycle
// turns those fields into held control selects and an execution delay D. The
// controller then either counts D cycles (EXEC) or waits for alu_done (WAIT,
// used when D is all-ones). Every instruction that is not flushed ends with
// exactly one retire pulse. An illegal instruction skips execution: it
// retires straight from DECODE with illegal=1 and all selects 0.
//
// Ports
//   clk, rst_b          clock (rising edge), asynchronous active-low reset
//   instr_valid/ready   instruction handshake; ready is high only in IDLE
//   opr_code, dst_code  opcode and destination code
//   src_typ, dst_typ    operand types
//   alu_done            ALU completion; only looked at in WAIT
//   flush               aborts the instruction in DECODE/EXEC/WAIT
//   exec_start          one-cycle pulse in the first EXEC/WAIT cycle
//   busy                high in every state except IDLE
//   retire, illegal     end-of-instruction pulse; illegal qualifies it
//   opr_typ_sel         opcode latched at accept
//   opr_div_mod_sel     DIV/EVAL in modulo form (src_typ == 3'b100)
//   alu_o_sel/alu_t_sel ALU operand fetch enables
//   alu_typ_sel         ALU operation
//   prng_t_sel          PRNG seed load
//   prng_typ_sel        PRNG operation
//   sprf_typ_sel        field k drives index register k
//   dly_cnt             remaining EXEC cycles (debug)
// ---------------------------------------------------------------------------
module opr_issue_ctrl #(
  parameter int OPR_W      = 5,
  parameter int DST_W      = 8,
  parameter int DLY_W      = 8,
  parameter int ALU_TYP_W  = 4,
  parameter int PRNG_TYP_W = 2,
  parameter int SPRF_TYP_W = 2,
  parameter int NUM_IDX    = 2,
  parameter int IDX_BASE   = 32
) (
  input  logic                           clk,
  input  logic                           rst_b,
  input  logic                           instr_valid,
  output logic                           instr_ready,
  input  logic [OPR_W-1:0]               opr_code,
  input  logic [DST_W-1:0]               dst_code,
  input  logic [2:0]                     src_typ,
  input  logic [2:0]                     dst_typ,
  input  logic                           alu_done,
  input  logic                           flush,
  output logic                           exec_start,
  output logic                           busy,
  output logic                           retire,
  output logic                           illegal,
  output logic [OPR_W-1:0]               opr_typ_sel,
  output logic                           opr_div_mod_sel,
  output logic                           alu_o_sel,
  output logic                           alu_t_sel,
  output logic [ALU_TYP_W-1:0]           alu_typ_sel,
  output logic                           prng_t_sel,
  output logic [PRNG_TYP_W-1:0]          prng_typ_sel,
  output logic [NUM_IDX*SPRF_TYP_W-1:0]  sprf_typ_sel,
  output logic [DLY_W-1:0]               dly_cnt
);

  // Opcodes
  localparam logic [OPR_W-1:0] OP_MOV    = OPR_W'(1);
  localparam logic [OPR_W-1:0] OP_ADD    = OPR_W'(2);
  localparam logic [OPR_W-1:0] OP_SUB    = OPR_W'(3);
  localparam logic [OPR_W-1:0] OP_MUL    = OPR_W'(4);
  localparam logic [OPR_W-1:0] OP_DIV    = OPR_W'(5);
  localparam logic [OPR_W-1:0] OP_PRNG   = OPR_W'(6);
  localparam logic [OPR_W-1:0] OP_IDX    = OPR_W'(7);
  localparam logic [OPR_W-1:0] OP_INV    = OPR_W'(8);
  localparam logic [OPR_W-1:0] OP_SPLIT  = OPR_W'(9);
  localparam logic [OPR_W-1:0] OP_DEG    = OPR_W'(10);
  localparam logic [OPR_W-1:0] OP_RSHIFT = OPR_W'(11);
  localparam logic [OPR_W-1:0] OP_EVAL   = OPR_W'(12);
  localparam logic [OPR_W-1:0] OP_JMP    = OPR_W'(16);
  localparam logic [OPR_W-1:0] OP_JRE    = OPR_W'(17);

  // All-ones delay means "no fixed delay, wait for alu_done".
  localparam logic [DLY_W-1:0] D_WAIT = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_RETIRE
  } state_t;

  // Control selects held from DECODE until the next DECODE.
  typedef struct packed {
    logic                          div_mod;
    logic                          alu_o;
    logic                          alu_t;
    logic [ALU_TYP_W-1:0]          alu_typ;
    logic                          prng_t;
    logic [PRNG_TYP_W-1:0]         prng_typ;
    logic [NUM_IDX*SPRF_TYP_W-1:0] sprf;
  } sel_t;

  state_t state;
  state_t state_nxt;

  // Instruction fields captured at accept.
  logic [OPR_W-1:0] opr_q;
  logic [DST_W-1:0] dst_q;
  logic [2:0]       src_q;
  logic [2:0]       dtyp_q;

  sel_t             sel_q;

  // Decoder results
  logic                  dec_legal;
  logic [DLY_W-1:0]      dec_dly;
  sel_t                  dec_sel;
  logic                  alu_en;
  logic                  sprf_en;
  logic [SPRF_TYP_W-1:0] sprf_val;
  logic [5:0]            dst_idx;
  int                    idx_off;

  // FSM strobes
  logic accept;
  logic do_flush;

  // Only dst_code[5:0] addresses registers; the upper bits are don't-care.
  logic unused_dst_hi;
  assign unused_dst_hi = ^dst_q[DST_W-1:6];

  // -------------------------------------------------------------------------
  // Decoder: latched fields -> legality, delay, selects
  // -------------------------------------------------------------------------
  assign dst_idx = dst_q[5:0];

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    dec_legal = 1'b0;
    dec_dly   = '0;
    dec_sel   = '0;
    alu_en    = 1'b0;
    sprf_en   = 1'b0;
    sprf_val  = '0;
    idx_off   = int'(dst_idx) - IDX_BASE;

    case (opr_q)
      OP_MOV: begin
        dec_legal = 1'b1;
        case ({src_q, dtyp_q})
          6'b101_000,
          6'b101_100: dec_dly = DLY_W'(4);   // @IDX -> Rx / Rmod
          6'b010_000: dec_dly = DLY_W'(1);   // imm -> Rx
          6'b000_000: begin                  // Rx -> Rx, may load an index reg
            dec_dly  = DLY_W'(1);
            sprf_en  = 1'b1;
            sprf_val = SPRF_TYP_W'(1);
          end
          6'b000_100: dec_dly = DLY_W'(1);   // Rx -> Rmod
          6'b000_101: dec_dly = DLY_W'(2);   // Rx -> @IDX
          default:    dec_legal = 1'b0;
        endcase
      end
      OP_ADD:    begin dec_legal = 1'b1; alu_en = 1'b1; dec_dly = DLY_W'(4);  dec_sel.alu_typ = ALU_TYP_W'(1); end
      OP_SUB:    begin dec_legal = 1'b1; alu_en = 1'b1; dec_dly = DLY_W'(4);  dec_sel.alu_typ = ALU_TYP_W'(2); end
      OP_MUL:    begin dec_legal = 1'b1; alu_en = 1'b1; dec_dly = D_WAIT;     dec_sel.alu_typ = ALU_TYP_W'(3); end
      OP_DIV: begin
        dec_legal       = 1'b1;
        alu_en          = 1'b1;
        dec_dly         = D_WAIT;
        dec_sel.alu_typ = ALU_TYP_W'(5);
        dec_sel.div_mod = (src_q == 3'b100);
      end
      OP_INV:    begin dec_legal = 1'b1; alu_en = 1'b1; dec_dly = DLY_W'(21); dec_sel.alu_typ = ALU_TYP_W'(6); end
      OP_SPLIT:  begin dec_legal = 1'b1; alu_en = 1'b1; dec_dly = D_WAIT;     dec_sel.alu_typ = ALU_TYP_W'(2); end
      OP_DEG:    begin dec_legal = 1'b1; alu_en = 1'b1; dec_dly = D_WAIT;     dec_sel.alu_typ = ALU_TYP_W'(7); end
      OP_RSHIFT: begin dec_legal = 1'b1; alu_en = 1'b1; dec_dly = D_WAIT;     dec_sel.alu_typ = ALU_TYP_W'(8); end
      OP_EVAL: begin
        dec_legal       = 1'b1;
        alu_en          = 1'b1;
        dec_dly         = DLY_W'(34);
        dec_sel.alu_typ = ALU_TYP_W'(9);
        dec_sel.div_mod = (src_q == 3'b100);
      end
      OP_JRE:    begin dec_legal = 1'b1; alu_en = 1'b1; dec_dly = DLY_W'(7);  dec_sel.alu_typ = ALU_TYP_W'(4); end
      OP_JMP:    begin dec_legal = 1'b1; dec_dly = DLY_W'(3); end
      OP_PRNG: begin
        if ({src_q, dtyp_q} == 6'b010_000) begin        // seed load
          dec_legal        = 1'b1;
          dec_dly          = DLY_W'(3);
          dec_sel.prng_t   = 1'b1;
          dec_sel.prng_typ = PRNG_TYP_W'(2);
        end else if ({src_q, dtyp_q} == 6'b000_000) begin
          dec_legal        = 1'b1;
          dec_dly          = DLY_W'(4);
          dec_sel.prng_typ = PRNG_TYP_W'(1);
        end
      end
      OP_IDX: begin
        if (dtyp_q == 3'b000) begin                      // increment
          dec_legal = 1'b1;
          dec_dly   = DLY_W'(2);
          sprf_en   = 1'b1;
          sprf_val  = SPRF_TYP_W'(2);
        end else if (dtyp_q == 3'b001) begin             // decrement
          dec_legal = 1'b1;
          dec_dly   = DLY_W'(2);
          sprf_en   = 1'b1;
          sprf_val  = SPRF_TYP_W'(3);
        end
      end
      default: dec_legal = 1'b0;
    endcase

    dec_sel.alu_o = alu_en;
    dec_sel.alu_t = alu_en;

    // A destination outside the index window matches no k and leaves every
    // field 0; the instruction itself stays legal.
    for (int k = 0; k < NUM_IDX; k++) begin
      if (sprf_en && (idx_off == k)) begin
        dec_sel.sprf[k*SPRF_TYP_W +: SPRF_TYP_W] = sprf_val;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    do_flush  = 1'b0;
    case (state)
      S_IDLE: begin
        if (instr_valid) begin
          accept    = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (flush) begin
          do_flush  = 1'b1;
          state_nxt = S_IDLE;
        end else if (!dec_legal) begin
          state_nxt = S_RETIRE;
        end else if (dec_dly == D_WAIT) begin
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (flush) begin
          do_flush  = 1'b1;
          state_nxt = S_IDLE;
        end else if (dly_cnt <= DLY_W'(1)) begin
          // Leaving on the dly_cnt==1 cycle makes EXEC last exactly D cycles.
          state_nxt = S_RETIRE;
        end
      end
      S_WAIT: begin
        if (flush) begin
          do_flush  = 1'b1;
          state_nxt = S_IDLE;
        end else if (alu_done) begin
          state_nxt = S_RETIRE;
        end
      end
      S_RETIRE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);

  // -------------------------------------------------------------------------
  // Field capture, selects, delay counter and pulse outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      opr_q       <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      dtyp_q      <= '0;
      opr_typ_sel <= '0;
      sel_q       <= '0;
      dly_cnt     <= '0;
      exec_start  <= 1'b0;
      retire      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      // Pulses are registered from the next state so they line up with the
      // state they announce and carry no decode glitches.
      exec_start <= (state == S_DECODE) &&
                    ((state_nxt == S_EXEC) || (state_nxt == S_WAIT));
      retire     <= (state_nxt == S_RETIRE);
      illegal    <= (state == S_DECODE) && (state_nxt == S_RETIRE);

      if (accept) begin
        opr_q       <= opr_code;
        dst_q       <= dst_code;
        src_q       <= src_typ;
        dtyp_q      <= dst_typ;
        opr_typ_sel <= opr_code;
      end

      if (do_flush) begin
        sel_q   <= '0;
        dly_cnt <= '0;
      end else if (state == S_DECODE) begin
        sel_q   <= dec_legal ? dec_sel : '0;
        dly_cnt <= dec_legal ? dec_dly : '0;
      end else if (state == S_EXEC) begin
        dly_cnt <= dly_cnt - DLY_W'(1);
      end
    end
  end

  assign opr_div_mod_sel = sel_q.div_mod;
  assign alu_o_sel       = sel_q.alu_o;
  assign alu_t_sel       = sel_q.alu_t;
  assign alu_typ_sel     = sel_q.alu_typ;
  assign prng_t_sel      = sel_q.prng_t;
  assign prng_typ_sel    = sel_q.prng_typ;
  assign sprf_typ_sel    = sel_q.sprf;

endmodule

// File: tb/tb_opr_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_opr_issue_ctrl
//
// Bench for opr_issue_ctrl with NUM_IDX=4. A table of instruction records
// carries the inputs and the expected selects/latency; each record is pushed
// to a scoreboard queue when driven and popped by a monitor when retire
// appears. Hand-written sequences cover reset, detailed ADD timing, flush,
// back-to-back issue and reset during EXEC.
// ---------------------------------------------------------------------------
module tb_opr_issue_ctrl;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  opr_code;
  logic [7:0]  dst_code;
  logic [2:0]  src_typ;
  logic [2:0]  dst_typ;
  logic        alu_done;
  logic        flush;
  logic        exec_start;
  logic        busy;
  logic        retire;
  logic        illegal;
  logic [4:0]  opr_typ_sel;
  logic        opr_div_mod_sel;
  logic        alu_o_sel;
  logic        alu_t_sel;
  logic [3:0]  alu_typ_sel;
  logic        prng_t_sel;
  logic [1:0]  prng_typ_sel;
  logic [7:0]  sprf_typ_sel;
  logic [7:0]  dly_cnt;

  opr_issue_ctrl #(.NUM_IDX(NI)) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .opr_code        (opr_code),
    .dst_code        (dst_code),
    .src_typ         (src_typ),
    .dst_typ         (dst_typ),
    .alu_done        (alu_done),
    .flush           (flush),
    .exec_start      (exec_start),
    .busy            (busy),
    .retire          (retire),
    .illegal         (illegal),
    .opr_typ_sel     (opr_typ_sel),
    .opr_div_mod_sel (opr_div_mod_sel),
    .alu_o_sel       (alu_o_sel),
    .alu_t_sel       (alu_t_sel),
    .alu_typ_sel     (alu_typ_sel),
    .prng_t_sel      (prng_t_sel),
    .prng_typ_sel    (prng_typ_sel),
    .sprf_typ_sel    (sprf_typ_sel),
    .dly_cnt         (dly_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] opr;
    logic [7:0] dst;
    logic [2:0] src;
    logic [2:0] dtyp;
    int         done_dly;  // cycles after exec_start until alu_done; -1: none
    bit         ill;
    int         lat;       // cycles from accept cycle to retire cycle
    logic [3:0] alu_typ;
    bit         alu_ot;
    bit         prng_t;
    logic [1:0] prng_typ;
    logic [7:0] sprf;
    bit         div_mod;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int exec_cyc = 0;
  bit seen_exec = 1'b0;
  int n_retire = 0;

  localparam logic [35:0] RESET_OUTS = {1'b1, 35'd0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [35:0] outs();
    return {instr_ready, busy, exec_start, retire, illegal, opr_typ_sel,
            opr_div_mod_sel, alu_o_sel, alu_t_sel, alu_typ_sel,
            prng_t_sel, prng_typ_sel, sprf_typ_sel, dly_cnt};
  endfunction

  function automatic vec_t mk(input logic [4:0] opr, input logic [7:0] dst,
                              input logic [2:0] src, input logic [2:0] dtyp,
                              input int done_dly, input bit ill, input int lat,
                              input logic [3:0] alu_typ, input bit alu_ot,
                              input bit prng_t, input logic [1:0] prng_typ,
                              input logic [7:0] sprf, input bit div_mod);
    vec_t v;
    v.opr = opr; v.dst = dst; v.src = src; v.dtyp = dtyp;
    v.done_dly = done_dly; v.ill = ill; v.lat = lat;
    v.alu_typ = alu_typ; v.alu_ot = alu_ot; v.prng_t = prng_t;
    v.prng_typ = prng_typ; v.sprf = sprf; v.div_mod = div_mod;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard consumer
  always @(negedge clk) begin
    vec_t e;
    if (rst_b) begin
      if (instr_valid && instr_ready) begin
        acc_cyc   = cyc;
        seen_exec = 1'b0;
      end
      if (exec_start) begin
        seen_exec = 1'b1;
        exec_cyc  = cyc;
      end
      if (retire) begin
        n_retire++;
        check("retire_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
          check("illegal", 64'(illegal), 64'(e.ill));
          if (e.ill) begin
            check("no_exec_start", 64'(seen_exec), 64'd0);
          end else begin
            check("exec_start_at_2", 64'(seen_exec ? exec_cyc - acc_cyc : -1), 64'd2);
            check("opr_typ_sel", 64'(opr_typ_sel), 64'(e.opr));
          end
          check("alu_sel", 64'({opr_div_mod_sel, alu_o_sel, alu_t_sel, alu_typ_sel}),
                64'({e.div_mod, e.alu_ot, e.alu_ot, e.alu_typ}));
          check("prng_sel", 64'({prng_t_sel, prng_typ_sel}), 64'({e.prng_t, e.prng_typ}));
          check("sprf_sel", 64'(sprf_typ_sel), 64'(e.sprf));
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int g = 0;
    while (!instr_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    check(name, 64'(instr_ready), 64'd1);
  endtask

  task automatic wait_exec(input string name);
    int g = 0;
    while (!exec_start && g < 50) begin
      @(negedge clk);
      g++;
    end
    check(name, 64'(exec_start), 64'd1);
  endtask

  task automatic drive(input vec_t v);
    opr_code = v.opr; dst_code = v.dst; src_typ = v.src; dst_typ = v.dtyp;
    instr_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    wait_idle("ready_before_send");
    drive(v);
    sb_q.push_back(v);
    @(negedge clk);
    instr_valid = 1'b0;
    if (v.done_dly >= 0) begin
      wait_exec("wait_exec_start");
      repeat (v.done_dly) @(negedge clk);
      alu_done = 1'b1;
      @(negedge clk);
      alu_done = 1'b0;
    end
    wait_idle("ready_after_send");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int acc_t[3];
    int na;
    int g;
    int r0;

    rst_b = 1'b0; instr_valid = 1'b0; opr_code = '0; dst_code = '0;
    src_typ = '0; dst_typ = '0; alu_done = 1'b0; flush = 1'b0;

    //                opr    dst     src     dtyp  done ill lat alu  ot pt ptyp  sprf  dm
    vecs.push_back(mk(5'd2,  8'd0,  3'b000,3'b000, -1, 0,  6, 4'd1, 1, 0,2'd0,8'h00,0)); // ADD
    vecs.push_back(mk(5'd6,  8'd0,  3'b010,3'b000, -1, 0,  5, 4'd0, 0, 1,2'd2,8'h00,0)); // PRNG seed
    vecs.push_back(mk(5'd3,  8'd0,  3'b000,3'b000, -1, 0,  6, 4'd2, 1, 0,2'd0,8'h00,0)); // SUB
    vecs.push_back(mk(5'd4,  8'd0,  3'b000,3'b000, 10, 0, 13, 4'd3, 1, 0,2'd0,8'h00,0)); // MUL
    vecs.push_back(mk(5'd5,  8'd0,  3'b100,3'b000,  3, 0,  6, 4'd5, 1, 0,2'd0,8'h00,1)); // DIV mod
    vecs.push_back(mk(5'd5,  8'd0,  3'b000,3'b000,  1, 0,  4, 4'd5, 1, 0,2'd0,8'h00,0)); // DIV
    vecs.push_back(mk(5'd8,  8'd0,  3'b000,3'b000, -1, 0, 23, 4'd6, 1, 0,2'd0,8'h00,0)); // INV
    vecs.push_back(mk(5'd9,  8'd0,  3'b000,3'b000,  0, 0,  3, 4'd2, 1, 0,2'd0,8'h00,0)); // SPLIT
    vecs.push_back(mk(5'd10, 8'd0,  3'b000,3'b000,  5, 0,  8, 4'd7, 1, 0,2'd0,8'h00,0)); // DEG
    vecs.push_back(mk(5'd11, 8'd0,  3'b000,3'b000,  2, 0,  5, 4'd8, 1, 0,2'd0,8'h00,0)); // RSHIFT
    vecs.push_back(mk(5'd12, 8'd0,  3'b100,3'b000, -1, 0, 36, 4'd9, 1, 0,2'd0,8'h00,1)); // EVAL mod
    vecs.push_back(mk(5'd17, 8'd0,  3'b000,3'b000, -1, 0,  9, 4'd4, 1, 0,2'd0,8'h00,0)); // JRE
    vecs.push_back(mk(5'd16, 8'd0,  3'b000,3'b000, -1, 0,  5, 4'd0, 0, 0,2'd0,8'h00,0)); // JMP
    vecs.push_back(mk(5'd6,  8'd0,  3'b000,3'b000, -1, 0,  6, 4'd0, 0, 0,2'd1,8'h00,0)); // PRNG
    vecs.push_back(mk(5'd6,  8'd0,  3'b101,3'b000, -1, 1,  2, 4'd0, 0, 0,2'd0,8'h00,0)); // PRNG bad
    vecs.push_back(mk(5'd1,  8'd0,  3'b101,3'b000, -1, 0,  6, 4'd0, 0, 0,2'd0,8'h00,0)); // MOV @IDX->Rx
    vecs.push_back(mk(5'd1,  8'd0,  3'b101,3'b100, -1, 0,  6, 4'd0, 0, 0,2'd0,8'h00,0)); // MOV @IDX->Rmod
    vecs.push_back(mk(5'd1,  8'd0,  3'b010,3'b000, -1, 0,  3, 4'd0, 0, 0,2'd0,8'h00,0)); // MOV imm
    vecs.push_back(mk(5'd1,  8'd33, 3'b000,3'b000, -1, 0,  3, 4'd0, 0, 0,2'd0,8'h04,0)); // MOV load idx1
    vecs.push_back(mk(5'd1,  8'hE3, 3'b000,3'b000, -1, 0,  3, 4'd0, 0, 0,2'd0,8'h40,0)); // MOV load idx3
    vecs.push_back(mk(5'd1,  8'd0,  3'b000,3'b100, -1, 0,  3, 4'd0, 0, 0,2'd0,8'h00,0)); // MOV Rx->Rmod
    vecs.push_back(mk(5'd1,  8'd0,  3'b000,3'b101, -1, 0,  4, 4'd0, 0, 0,2'd0,8'h00,0)); // MOV Rx->@IDX
    vecs.push_back(mk(5'd1,  8'd0,  3'b001,3'b000, -1, 1,  2, 4'd0, 0, 0,2'd0,8'h00,0)); // MOV bad
    vecs.push_back(mk(5'd7,  8'd34, 3'b000,3'b001, -1, 0,  4, 4'd0, 0, 0,2'd0,8'h30,0)); // IDX dec k2
    vecs.push_back(mk(5'd7,  8'd40, 3'b000,3'b001, -1, 0,  4, 4'd0, 0, 0,2'd0,8'h00,0)); // IDX out of range
    vecs.push_back(mk(5'd7,  8'd32, 3'b000,3'b000, -1, 0,  4, 4'd0, 0, 0,2'd0,8'h02,0)); // IDX inc k0
    vecs.push_back(mk(5'd7,  8'd33, 3'b000,3'b010, -1, 1,  2, 4'd0, 0, 0,2'd0,8'h00,0)); // IDX bad
    vecs.push_back(mk(5'd13, 8'd0,  3'b000,3'b000, -1, 1,  2, 4'd0, 0, 0,2'd0,8'h00,0)); // op 13
    vecs.push_back(mk(5'd0,  8'd0,  3'b000,3'b000, -1, 1,  2, 4'd0, 0, 0,2'd0,8'h00,0)); // op 0
    vecs.push_back(mk(5'd18, 8'd0,  3'b000,3'b000, -1, 1,  2, 4'd0, 0, 0,2'd0,8'h00,0)); // op 18
    vecs.push_back(mk(5'd31, 8'd0,  3'b000,3'b000, -1, 1,  2, 4'd0, 0, 0,2'd0,8'h00,0)); // op 31

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_outs", 64'(outs()), 64'(RESET_OUTS));
    rst_b = 1'b1;
    @(negedge clk);
    check("after_reset_outs", 64'(outs()), 64'(RESET_OUTS));

    // ADD accepted at cycle 0: detailed timing
    drive(vecs[0]);
    sb_q.push_back(vecs[0]);
    @(negedge clk);                           // cycle 1: DECODE
    instr_valid = 1'b0;
    check("add_c1_ready_busy_es", 64'({instr_ready, busy, exec_start}), 64'(3'b010));
    @(negedge clk);                           // cycle 2: first EXEC
    check("add_c2_exec_start", 64'(exec_start), 64'd1);
    check("add_c2_dly", 64'(dly_cnt), 64'd4);
    for (int i = 3; i <= 5; i++) begin
      @(negedge clk);
      check("add_dly_count", 64'(dly_cnt), 64'(6 - i));
      check("add_exec_start_low", 64'(exec_start), 64'd0);
    end
    @(negedge clk);                           // cycle 6: RETIRE
    check("add_c6_retire", 64'(retire), 64'd1);
    check("add_c6_alu_typ", 64'(alu_typ_sel), 64'd1);
    @(negedge clk);                           // cycle 7: IDLE
    check("add_c7_ready", 64'({instr_ready, busy}), 64'(2'b10));

    // Table
    foreach (vecs[i]) send(vecs[i]);

    // Flush during WAIT of DIV: IDLE at once, selects cleared, no retire
    wait_idle("ready_before_flush");
    v = mk(5'd5, 8'd0, 3'b100, 3'b000, -1, 0, 0, 4'd5, 1, 0, 2'd0, 8'h00, 1);
    drive(v);
    @(negedge clk);
    instr_valid = 1'b0;
    wait_exec("flush_div_exec_start");
    r0 = n_retire;
    @(negedge clk);
    check("flush_div_waiting", 64'({busy, alu_typ_sel, opr_div_mod_sel}), 64'({1'b1, 4'd5, 1'b1}));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", 64'({instr_ready, busy}), 64'(2'b10));
    check("flush_sel_clear", 64'({opr_div_mod_sel, alu_o_sel, alu_t_sel, alu_typ_sel, dly_cnt}), 64'd0);
    alu_done = 1'b1;                          // ignored outside WAIT
    @(negedge clk);
    alu_done = 1'b0;
    repeat (4) @(negedge clk);
    check("flush_no_retire", 64'(n_retire - r0), 64'd0);
    check("flush_still_idle", 64'(busy), 64'd0);

    // Flush while IDLE is ignored: JMP proceeds normally
    v = mk(5'd16, 8'd0, 3'b000, 3'b000, -1, 0, 5, 4'd0, 0, 0, 2'd0, 8'h00, 0);
    drive(v);
    flush = 1'b1;
    sb_q.push_back(v);
    @(negedge clk);
    instr_valid = 1'b0;
    flush = 1'b0;
    wait_idle("idle_flush_jmp_done");

    // Back-to-back JMPs: one accept per 3+D = 6 cycles
    drive(v);
    repeat (3) sb_q.push_back(v);
    na = 0;
    g  = 0;
    while (na < 3 && g < 200) begin
      if (instr_ready) begin
        acc_t[na] = cyc;
        na++;
      end
      if (na < 3) begin
        @(negedge clk);
        g++;
      end
    end
    @(negedge clk);
    instr_valid = 1'b0;
    check("b2b_accepts", 64'(na), 64'd3);
    check("b2b_gap0", 64'(acc_t[1] - acc_t[0]), 64'd6);
    check("b2b_gap1", 64'(acc_t[2] - acc_t[1]), 64'd6);
    wait_idle("b2b_done");

    // Reset during EXEC of EVAL: immediate return to reset values
    v = mk(5'd12, 8'd0, 3'b000, 3'b000, -1, 0, 0, 4'd9, 1, 0, 2'd0, 8'h00, 0);
    drive(v);
    @(negedge clk);
    instr_valid = 1'b0;
    wait_exec("eval_exec_start");
    repeat (5) @(negedge clk);
    check("eval_running", 64'({busy, alu_typ_sel}), 64'({1'b1, 4'd9}));
    r0 = n_retire;
    rst_b = 1'b0;
    #1;
    check("midop_reset_outs", 64'(outs()), 64'(RESET_OUTS));
    @(negedge clk);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("midop_reset_after", 64'(outs()), 64'(RESET_OUTS));
    check("midop_reset_no_retire", 64'(n_retire - r0), 64'd0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
